mc_ctrl: RTL

- Multi-cycle main controller for the MIPS core.
- Sequences fetch/decode/execute/memory/writeback over the shared datapath: PC register, NPC unit, IR, GRF, ALU, EXT, DM.
- Decides when the PC register loads and which NPC source (nPC_Sel) it loads from.
- Runs a handshake with instruction and data memory so the core tolerates multi-cycle memories.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_ctrl_decode.sv | 33 +++
 rtl/mc_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller.
// NPC codes, opcodes, datapath selects, state encodings.
package mc_ctrl_pkg;

  localparam logic [2:0] NPC_PC4    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_NOP  = 6'h00;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] A3_RT = 2'd0;
  localparam logic [1:0] A3_RD = 2'd1;
  localparam logic [1:0] A3_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6
  } state_t;

  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic nop;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction classifier: op/funct to a one-hot class.
// Exactly one class bit is set for any op/funct pair.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU,
          FN_SUBU: cls.rtype_alu = 1'b1;
          FN_JR:   cls.jr        = 1'b1;
          FN_NOP:  cls.nop       = 1'b1;
          default: cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller with IM/DM ready handshake.
// Optional retired-instruction counter: MC_CTRL_INSTRET_EN.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       im_ready,
  input  logic       dm_ready,
  output logic       im_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [2:0] npc_sel,
  output logic       grf_we,
  output logic [1:0] a3_sel,
  output logic [1:0] wd_sel,
  output logic [1:0] ext_op,
  output logic       alub_sel,
  output logic [2:0] alu_op,
  output logic       dm_re,
  output logic       dm_we,
  output logic       illegal,
  output logic [3:0] state
`ifdef MC_CTRL_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  state_t  state_q;
  state_t  state_d;
  iclass_t cls;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (im_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (cls.nop | cls.illegal | cls.jal | cls.jr)
          state_d = S_FETCH;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          cls.lw:  state_d = S_MEM_RD;
          cls.sw:  state_d = S_MEM_WR;
          cls.rtype_alu,
          cls.ori,
          cls.lui: state_d = S_WB_ALU;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: if (dm_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (dm_ready) state_d = S_FETCH;
      S_WB_ALU: state_d = S_FETCH;
      S_WB_MEM: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    im_req   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = NPC_PC4;
    grf_we   = 1'b0;
    a3_sel   = A3_RT;
    wd_sel   = WD_ALU;
    ext_op   = EXT_ZERO;
    alub_sel = 1'b0;
    alu_op   = ALU_ADD;
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    illegal  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          im_req = 1'b1;
          ir_we  = im_ready;
        end
        S_DECODE: begin
          unique case (1'b1)
            cls.nop: pc_we = 1'b1;
            cls.illegal: begin
              illegal = 1'b1;
              pc_we   = 1'b1;
            end
            cls.jal: begin
              grf_we  = 1'b1;
              a3_sel  = A3_RA;
              wd_sel  = WD_PC4;
              pc_we   = 1'b1;
              npc_sel = NPC_JUMP;
            end
            cls.jr: begin
              pc_we   = 1'b1;
              npc_sel = NPC_JR;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          unique case (1'b1)
            cls.rtype_alu: begin
              alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            cls.ori: begin
              ext_op   = EXT_ZERO;
              alub_sel = 1'b1;
              alu_op   = ALU_OR;
            end
            cls.lui: begin
              ext_op   = EXT_LUI;
              alub_sel = 1'b1;
            end
            cls.lw,
            cls.sw: begin
              ext_op   = EXT_SIGN;
              alub_sel = 1'b1;
            end
            cls.beq: begin
              alu_op  = ALU_SUB;
              pc_we   = 1'b1;
              npc_sel = NPC_BRANCH;
            end
            default: ;
          endcase
        end
        S_MEM_RD: dm_re = 1'b1;
        S_MEM_WR: begin
          dm_we = 1'b1;
          pc_we = dm_ready;
        end
        S_WB_ALU: begin
          grf_we = 1'b1;
          wd_sel = WD_ALU;
          a3_sel = cls.rtype_alu ? A3_RD : A3_RT;
          pc_we  = 1'b1;
        end
        S_WB_MEM: begin
          grf_we = 1'b1;
          wd_sel = WD_DM;
          a3_sel = A3_RT;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

`ifdef MC_CTRL_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset)
      instret_q <= '0;
    else if (pc_we && !illegal)
      instret_q <= instret_q + INSTRET_W'(1);
  end

  assign instret = instret_q;
`endif

endmodule
